multi_lfsr: RTL and testbench

Configurable multi-polynomial LFSR (m-sequence) generator. It produces a single-bit pseudo-random chip stream for the DAC stimulus path. The block selects one of eight maximal-length polynomials (degree 3–10), holds each chip for a programmable number of clocks, and repeats the full period a programmable number of times. It signals completion with a one-cycle flag.

---
 rtl/mul_lfsr_pkg.sv | 29 ++
 rtl/lfsr_core.sv | 43 ++++
 rtl/multi_lfsr.sv | 114 +++++++++++
 tb/tb_multi_lfsr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_lfsr_pkg.sv
// Shared types and polynomial tables for the multi-polynomial LFSR chip generator.
// Degree and tap tables are indexed by the 3-bit order select.
package mul_lfsr_pkg;

    localparam int MAX_DEG = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Entry [i] is the degree / Fibonacci tap mask for order i.
    localparam logic [7:0][3:0] DEG_TAB = {
        4'd10, 4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3
    };

    localparam logic [7:0][MAX_DEG-1:0] TAP_TAB = {
        10'h240, 10'h110, 10'h0B8, 10'h060, 10'h030, 10'h014, 10'h00C, 10'h006
    };

    // Low 'deg' bits set; also equals the period length 2^deg-1.
    function automatic logic [MAX_DEG-1:0] deg_mask(input logic [3:0] deg);
        logic [MAX_DEG:0] m;
        m = (11'd1 << deg) - 11'd1;
        return m[MAX_DEG-1:0];
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Variable-degree (3..10) Fibonacci LFSR with per-period chip counter.
// Latency: shifts on the clock where step is high; out_bit/eop are combinational from state.
// Backpressure: none; advances only when step is asserted.
module lfsr_core
    import mul_lfsr_pkg::*;
(
    input  logic               clk,
    input  logic               srst,
    input  logic               load,
    input  logic               step,
    input  logic [3:0]         degree,
    input  logic [MAX_DEG-1:0] tap_mask,
    output logic               out_bit,
    output logic               eop
);

    logic [MAX_DEG-1:0] lfsr_q;
    logic [MAX_DEG-1:0] chip_cnt;
    logic [MAX_DEG-1:0] mask;
    logic               fb;

    assign mask    = deg_mask(degree);
    assign fb      = ^(lfsr_q & tap_mask);
    assign out_bit = lfsr_q[degree - 4'd1];
    // Last chip index of the period is 2^n-2, i.e. mask-1.
    assign eop     = (chip_cnt == (mask - 10'd1));

    always_ff @(posedge clk) begin
        if (srst || load) begin
            lfsr_q   <= '1;
            chip_cnt <= '0;
        end else if (step) begin
            lfsr_q   <= {lfsr_q[MAX_DEG-2:0], fb} & mask;
            chip_cnt <= eop ? '0 : chip_cnt + 10'd1;
        end
    end

`ifdef MUL_LFSR_ASSERT_EN
    a_lfsr_nonzero: assert property (@(posedge clk) disable iff (srst)
        (lfsr_q & mask) != '0);
`endif

endmodule

// File: rtl/multi_lfsr.sv
// Multi-polynomial m-sequence chip generator: FSM, chip divider, period counter.
// Latency: first chip on sig_o two edges after en is sampled high in IDLE; each chip held D clocks.
// Backpressure: none; en low aborts. Optional checks under MUL_LFSR_ASSERT_EN.
module multi_lfsr
    import mul_lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       en,
    input  logic [7:0] sel_div_i,
    input  logic [2:0] rep_i,
    input  logic [7:0] order_i,
    output logic       flag_o,
    output logic       sig_o
);

    state_t       state;
    logic [2:0]   order_q;
    logic [7:0]   div_q;
    logic [2:0]   rep_q;
    logic [7:0]   div_cnt;
    logic [2:0]   per_cnt;
    logic [7:0]   div_last;
    logic         chip_end;
    logic         finishing;
    logic         core_load;
    logic         core_step;
    logic         core_bit;
    logic         core_eop;

    assign div_last  = (div_q == 8'd0) ? 8'd0 : div_q - 8'd1;
    assign chip_end  = (div_cnt == div_last);
    // Clock after the terminal flag: park in DONE without emitting another chip.
    assign finishing = flag_o && (rep_q != 3'd0);
    assign core_load = (state == IDLE) && en;
    assign core_step = (state == RUN) && en && !finishing && chip_end;

    lfsr_core u_core (
        .clk      (clk),
        .srst     (srst),
        .load     (core_load),
        .step     (core_step),
        .degree   (DEG_TAB[order_q]),
        .tap_mask (TAP_TAB[order_q]),
        .out_bit  (core_bit),
        .eop      (core_eop)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state   <= IDLE;
            sig_o   <= 1'b0;
            flag_o  <= 1'b0;
            order_q <= '0;
            div_q   <= '0;
            rep_q   <= '0;
            div_cnt <= '0;
            per_cnt <= '0;
        end else begin
            sig_o  <= 1'b0;
            flag_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        order_q <= order_i[2:0];
                        div_q   <= sel_div_i;
                        rep_q   <= rep_i;
                        div_cnt <= '0;
                        per_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                    end else if (finishing) begin
                        state <= DONE;
                    end else begin
                        sig_o <= core_bit;
                        if (chip_end) begin
                            div_cnt <= '0;
                            if (core_eop) begin
                                if (rep_q == 3'd0) begin
                                    flag_o <= 1'b1;
                                end else begin
                                    per_cnt <= per_cnt + 3'd1;
                                    if ((per_cnt + 3'd1) == rep_q)
                                        flag_o <= 1'b1;
                                end
                            end
                        end else begin
                            div_cnt <= div_cnt + 8'd1;
                        end
                    end
                end
                DONE: begin
                    if (!en)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_LFSR_ASSERT_EN
    a_flag_single: assert property (@(posedge clk) disable iff (srst)
        flag_o |=> !flag_o);
    a_sig_idle: assert property (@(posedge clk)
        (state != RUN) |-> !sig_o);
    a_per_bound: assert property (@(posedge clk) disable iff (srst)
        (rep_q != 3'd0) |-> (per_cnt <= rep_q));
`endif

endmodule

// File: tb/tb_multi_lfsr.sv
// Scoreboard bench for multi_lfsr: expected {sig_o,flag_o} per clock queued at stimulus time.
module tb_multi_lfsr;

    logic       clk = 1'b0;
    logic       srst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] sel_div_i = '0;
    logic [2:0] rep_i = '0;
    logic [7:0] order_i = '0;
    logic       flag_o;
    logic       sig_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q [$];

    int         tb_deg  [8] = '{3, 4, 5, 6, 7, 8, 9, 10};
    logic [9:0] tb_taps [8] = '{10'h006, 10'h00C, 10'h014, 10'h030,
                                10'h060, 10'h0B8, 10'h110, 10'h240};

    always #5 clk = ~clk;

    multi_lfsr dut (
        .clk       (clk),
        .srst      (srst),
        .en        (en),
        .sel_div_i (sel_div_i),
        .rep_i     (rep_i),
        .order_i   (order_i),
        .flag_o    (flag_o),
        .sig_o     (sig_o)
    );

    // Expected stream: one idle clock, chips held d clocks, optional DONE tail.
    task automatic push_burst(input int order, input int d, input int periods,
                              input bit cont, input int limit);
        logic [9:0]  s;
        logic [10:0] m;
        logic        fb;
        int          n;
        int          plen;
        int          pushed;
        s = 10'h3FF;
        n = tb_deg[order];
        plen = (1 << n) - 1;
        m = (11'd1 << n) - 11'd1;
        pushed = 0;
        exp_q.push_back(2'b00);
        for (int p = 0; p < periods; p++) begin
            for (int c = 0; c < plen; c++) begin
                for (int k = 0; k < d; k++) begin
                    if (limit < 0 || pushed < limit) begin
                        exp_q.push_back({s[n-1], (c == plen-1) && (k == d-1) &&
                                                 (cont || p == periods-1)});
                        pushed++;
                    end
                end
                fb = ^(s & tb_taps[order]);
                s = {s[8:0], fb} & m[9:0];
            end
        end
        if (!cont && limit < 0)
            for (int i = 0; i < 3; i++) exp_q.push_back(2'b00);
    endtask

    task automatic start(input int order, input int div, input int rep);
        order_i   = order[7:0] | 8'hF8;
        sel_div_i = div[7:0];
        rep_i     = rep[2:0];
        en        = 1'b1;
    endtask

    task automatic stop_and_idle();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [1:0] e;
        for (int i = 0; i < 5; i++) exp_q.push_back(2'b00);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL reset: sig/flag got %b%b expected %b", sig_o, flag_o, e);
            end
        end
        srst = 1'b0;
        en   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_deg3_rep3();
        bit         chip3 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0] e;
        int         cyc;
        start(0, 4, 3);
        exp_q.push_back(2'b00);
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 7; c++)
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({chip3[c], (p == 2 && c == 6 && k == 3)});
        for (int i = 0; i < 3; i++) exp_q.push_back(2'b00);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL deg3_rep3 clk %0d: sig/flag got %b%b expected %b", cyc, sig_o, flag_o, e);
            end
            cyc++;
        end
        stop_and_idle();
    endtask

    task automatic test_deg4_div0();
        logic [1:0] e;
        int         cyc;
        start(1, 0, 1);
        push_burst(1, 1, 1, 1'b0, -1);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL deg4_div0 clk %0d: sig/flag got %b%b expected %b", cyc, sig_o, flag_o, e);
            end
            cyc++;
        end
        stop_and_idle();
    endtask

    task automatic test_continuous();
        logic [1:0] e;
        int         cyc;
        start(0, 1, 0);
        push_burst(0, 1, 6, 1'b1, 5 * 7 + 3);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL continuous clk %0d: sig/flag got %b%b expected %b", cyc, sig_o, flag_o, e);
            end
            cyc++;
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({sig_o, flag_o} !== 2'b00) begin
                n_fail++;
                $display("FAIL continuous_stop: sig/flag got %b%b expected 00", sig_o, flag_o);
            end
        end
    endtask

    task automatic test_abort();
        logic [1:0] e;
        start(2, 2, 2);
        push_burst(2, 2, 2, 1'b0, 10);
        for (int i = 0; i < 3; i++) exp_q.push_back(2'b00);
        for (int i = 0; i < 11 + 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL abort step %0d: sig/flag got %b%b expected %b", i, sig_o, flag_o, e);
            end
            if (i == 10) en = 1'b0;
        end
        start(2, 2, 2);
        push_burst(2, 2, 1, 1'b0, 4);
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL abort_restart: sig/flag got %b%b expected %b", sig_o, flag_o, e);
            end
        end
        stop_and_idle();
    endtask

    task automatic test_deg10();
        logic [1:0] e;
        int         cyc;
        int         flag_at;
        start(7, 1, 1);
        push_burst(7, 1, 1, 1'b0, -1);
        cyc = 0;
        flag_at = -1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (flag_o === 1'b1 && flag_at < 0) flag_at = cyc;
            n_checks++;
            if ({sig_o, flag_o} !== e) begin
                n_fail++;
                $display("FAIL deg10 clk %0d: sig/flag got %b%b expected %b", cyc, sig_o, flag_o, e);
            end
            cyc++;
        end
        n_checks++;
        if (flag_at != 1023) begin
            n_fail++;
            $display("FAIL deg10_flag_pos: flag at sample %0d expected 1023", flag_at);
        end
        n_checks++;
        if (dut.u_core.lfsr_q !== 10'h3FF) begin
            n_fail++;
            $display("FAIL deg10_seed_return: lfsr %h expected 3ff", dut.u_core.lfsr_q);
        end
        stop_and_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_deg3_rep3();
        test_deg4_div0();
        test_continuous();
        test_abort();
        test_deg10();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
